// File: rtl/fetch_align.sv
// Fetch stage: requests 16-byte I-cache lines and presents an 8-byte window
// at the current PC to the instruction buffer as tagged byte records.
module fetch_align #(
    parameter logic [31:0] RESET_PC   = 32'h0000_FFF0,
    parameter int          LINE_BYTES = 16
) (
    input  logic         CLK,
    input  logic         reset,
    output logic         ic_req,
    output logic [31:0]  ic_addr,
    input  logic         ic_rdy,
    input  logic [127:0] ic_line,
    input  logic         ib_ready,
    input  logic         redirect,
    input  logic [31:0]  redir_tgt,
    input  logic         redir_ex,
    input  logic         bp_taken,
    input  logic [31:0]  bp_tgt,
    output logic [77:0]  b0,
    output logic [77:0]  b1,
    output logic [77:0]  b2,
    output logic [77:0]  b3,
    output logic [77:0]  b4,
    output logic [77:0]  b5,
    output logic [77:0]  b6,
    output logic [77:0]  b7,
    output logic         fetch_not_ready,
    output logic [3:0]   fetch_width,
    output logic         page_bound
);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_DELIVER,
        ST_HOLD
    } state_t;

    localparam logic [4:0] LINE_SZ = 5'(LINE_BYTES);

    state_t         state;
    logic [31:0]    pc;
    logic [3:0]     fetch_id;
    logic           ex_flag;
    logic           squash;
    logic [127:0]   line_buf;

    logic [3:0]     off;
    logic           pb_w;
    logic [3:0]     width_w;
    logic [31:0]    step;
    logic [31:0]    next_pc_seq;
    logic           delivering;
    logic           win_valid;

    assign off         = pc[3:0];
    assign pb_w        = off > 4'd8;
    assign width_w     = pb_w ? 4'(LINE_SZ - {1'b0, off}) : 4'd8;
    assign step        = pb_w ? {28'b0, width_w} : 32'd8;
    assign next_pc_seq = pc + step;
    assign delivering  = (state == ST_DELIVER) || (state == ST_HOLD);
    assign win_valid   = delivering && !reset;

    // Slots past the line end replicate slot 0; the consumer ignores them.
    function automatic logic [77:0] make_rec(
        input logic [2:0]   k,
        input logic [3:0]   o,
        input logic [31:0]  base_pc,
        input logic [127:0] line,
        input logic [3:0]   fid,
        input logic         ex,
        input logic         bpt,
        input logic [31:0]  tgt
    );
        logic [4:0]  idx;
        logic [3:0]  sel;
        logic [31:0] bpc;
        idx = {1'b0, o} + {2'b0, k};
        sel = idx[4] ? o : idx[3:0];
        bpc = idx[4] ? base_pc : base_pc + {29'b0, k};
        return {ex, bpt, tgt, fid, bpc, line[{sel, 3'b000} +: 8]};
    endfunction

    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= ST_REQ;
            pc       <= RESET_PC;
            fetch_id <= 4'd0;
            ex_flag  <= 1'b0;
            squash   <= 1'b0;
            line_buf <= '0;
        end else if (redirect) begin
            pc       <= redir_tgt;
            fetch_id <= fetch_id + 4'd1;
            ex_flag  <= redir_ex;
            state    <= ST_REQ;
            // A request still in flight must have its response dropped later.
            squash   <= (state == ST_WAIT) ? (!ic_rdy || squash) : (squash && !ic_rdy);
        end else begin
            if (squash && ic_rdy) begin
                squash <= 1'b0;
            end
            case (state)
                ST_REQ: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (ic_rdy && !squash) begin
                        line_buf <= ic_line;
                        state    <= ST_DELIVER;
                    end
                end
                ST_DELIVER, ST_HOLD: begin
                    if (ib_ready) begin
                        ex_flag <= 1'b0;
                        if (bp_taken) begin
                            pc       <= bp_tgt;
                            fetch_id <= fetch_id + 4'd1;
                            state    <= ST_REQ;
                        end else begin
                            pc    <= next_pc_seq;
                            state <= (next_pc_seq[31:4] != pc[31:4]) ? ST_REQ : ST_DELIVER;
                        end
                    end else begin
                        state <= ST_HOLD;
                    end
                end
                default: state <= ST_REQ;
            endcase
        end
    end

    assign ic_req          = (state == ST_REQ) && !reset && !redirect;
    assign ic_addr         = {pc[31:4], 4'b0000};
    assign fetch_not_ready = !win_valid || redirect;
    assign page_bound      = win_valid && pb_w;
    assign fetch_width     = win_valid ? width_w : 4'd0;

    assign b0 = win_valid ? make_rec(3'd0, off, pc, line_buf, fetch_id, ex_flag, bp_taken, bp_tgt) : '0;
    assign b1 = win_valid ? make_rec(3'd1, off, pc, line_buf, fetch_id, ex_flag, bp_taken, bp_tgt) : '0;
    assign b2 = win_valid ? make_rec(3'd2, off, pc, line_buf, fetch_id, ex_flag, bp_taken, bp_tgt) : '0;
    assign b3 = win_valid ? make_rec(3'd3, off, pc, line_buf, fetch_id, ex_flag, bp_taken, bp_tgt) : '0;
    assign b4 = win_valid ? make_rec(3'd4, off, pc, line_buf, fetch_id, ex_flag, bp_taken, bp_tgt) : '0;
    assign b5 = win_valid ? make_rec(3'd5, off, pc, line_buf, fetch_id, ex_flag, bp_taken, bp_tgt) : '0;
    assign b6 = win_valid ? make_rec(3'd6, off, pc, line_buf, fetch_id, ex_flag, bp_taken, bp_tgt) : '0;
    assign b7 = win_valid ? make_rec(3'd7, off, pc, line_buf, fetch_id, ex_flag, bp_taken, bp_tgt) : '0;

endmodule
